// File: rtl/network_pkg.sv
// Shared widths, node identities and the port-to-node attachment of the 2x2 mesh.
// Top-level widths default from here; banks and pipelines derive their sizes from them.
package network_pkg;
   localparam int DEFAULT_DATA_WIDTH               = 8;
   localparam int DEFAULT_NETWORK_ADDRESS_WIDTH    = 2;
   localparam int DEFAULT_CACHE_BANK_ADDRESS_WIDTH = 4;
   localparam int NUM_PORTS                        = 4;

   typedef enum logic [1:0] {
      NODE_NORTH = 2'd0,
      NODE_EAST  = 2'd1,
      NODE_WEST  = 2'd2,
      NODE_SOUTH = 2'd3
   } nodeId_t;

   // Port 0 north, port 1 south, port 2 east, port 3 west.
   localparam nodeId_t PORT_NODE [NUM_PORTS] = '{NODE_NORTH, NODE_SOUTH, NODE_EAST, NODE_WEST};
endpackage

// File: rtl/network_cache_bank.sv
// One node's word store: 4 prioritized write ports (lowest index wins), 4 registered read ports.
// Reads sample the array before same-edge writes land, so a colliding read returns the old word.
module cache_bank
   import network_pkg::*;
#(
   parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
   parameter int WORD_ADDRESS_WIDTH = DEFAULT_CACHE_BANK_ADDRESS_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wrEn   [NUM_PORTS],
   input  logic [WORD_ADDRESS_WIDTH-1:0] wrAddr [NUM_PORTS],
   input  logic [DATA_WIDTH-1:0]         wrDat  [NUM_PORTS],
   input  logic [WORD_ADDRESS_WIDTH-1:0] rdAddr [NUM_PORTS],
   output logic [DATA_WIDTH-1:0]         rdDat  [NUM_PORTS]
);
   localparam int DEPTH = 1 << WORD_ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         for (int p = 0; p < NUM_PORTS; p++) rdDat[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) rdDat[p] <= mem[rdAddr[p]];
         // Highest index first so the last (winning) assignment comes from the lowest port.
         for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (wrEn[p]) mem[wrAddr[p]] <= wrDat[p];
         end
      end
   end
endmodule

// File: rtl/network.sv
// 4-port, 4-bank mesh memory: requests act on their bank 2 edges after sampling, reads return 4 edges after.
// Fixed latency everywhere, so each port takes one request per cycle with no back-pressure.
module network
   import network_pkg::*;
#(
   parameter int DATA_WIDTH               = DEFAULT_DATA_WIDTH,
   parameter int NETWORK_ADDRESS_WIDTH    = DEFAULT_NETWORK_ADDRESS_WIDTH,
   parameter int CACHE_BANK_ADDRESS_WIDTH = DEFAULT_CACHE_BANK_ADDRESS_WIDTH
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn_port0,
   input  logic                                                readIn_port0,
   input  logic                                                writeIn_port0,
   input  logic [DATA_WIDTH-1:0]                               dataIn_port0,
   output logic                                                readReady_port0,
   output logic [DATA_WIDTH-1:0]                               dataOut_port0,
   input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn_port1,
   input  logic                                                readIn_port1,
   input  logic                                                writeIn_port1,
   input  logic [DATA_WIDTH-1:0]                               dataIn_port1,
   output logic                                                readReady_port1,
   output logic [DATA_WIDTH-1:0]                               dataOut_port1,
   input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn_port2,
   input  logic                                                readIn_port2,
   input  logic                                                writeIn_port2,
   input  logic [DATA_WIDTH-1:0]                               dataIn_port2,
   output logic                                                readReady_port2,
   output logic [DATA_WIDTH-1:0]                               dataOut_port2,
   input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn_port3,
   input  logic                                                readIn_port3,
   input  logic                                                writeIn_port3,
   input  logic [DATA_WIDTH-1:0]                               dataIn_port3,
   output logic                                                readReady_port3,
   output logic [DATA_WIDTH-1:0]                               dataOut_port3
);
   localparam int AW    = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
   localparam int NAW   = NETWORK_ADDRESS_WIDTH;
   localparam int WAW   = CACHE_BANK_ADDRESS_WIDTH;
   localparam int NODES = 1 << NETWORK_ADDRESS_WIDTH;

   logic [AW-1:0]         addrIn [NUM_PORTS];
   logic                  rdIn   [NUM_PORTS];
   logic                  wrIn   [NUM_PORTS];
   logic [DATA_WIDTH-1:0] datIn  [NUM_PORTS];

   assign addrIn = '{destinationAddressIn_port0, destinationAddressIn_port1,
                     destinationAddressIn_port2, destinationAddressIn_port3};
   assign rdIn   = '{readIn_port0, readIn_port1, readIn_port2, readIn_port3};
   assign wrIn   = '{writeIn_port0, writeIn_port1, writeIn_port2, writeIn_port3};
   assign datIn  = '{dataIn_port0, dataIn_port1, dataIn_port2, dataIn_port3};

   // Request pipeline (s1, s2), then read-return tag (s3), routed data (s4) and output register.
   logic                  s1Vld [NUM_PORTS], s2Vld [NUM_PORTS];
   logic                  s1Wr  [NUM_PORTS], s2Wr  [NUM_PORTS];
   logic [AW-1:0]         s1Addr[NUM_PORTS], s2Addr[NUM_PORTS];
   logic [DATA_WIDTH-1:0] s1Dat [NUM_PORTS], s2Dat [NUM_PORTS];
   logic                  s3Vld [NUM_PORTS], s4Vld [NUM_PORTS];
   logic [NAW-1:0]        s3Node[NUM_PORTS];
   logic [DATA_WIDTH-1:0] s4Dat [NUM_PORTS];
   logic                  rdyQ  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] datQ  [NUM_PORTS];

   logic [WAW-1:0]        s2Word [NUM_PORTS];
   logic [DATA_WIDTH-1:0] bankRdDat [NODES][NUM_PORTS];

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) s2Word[p] = s2Addr[p][WAW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            s1Vld[p]  <= 1'b0;  s1Wr[p] <= 1'b0;  s1Addr[p] <= '0;  s1Dat[p] <= '0;
            s2Vld[p]  <= 1'b0;  s2Wr[p] <= 1'b0;  s2Addr[p] <= '0;  s2Dat[p] <= '0;
            s3Vld[p]  <= 1'b0;  s3Node[p] <= '0;
            s4Vld[p]  <= 1'b0;  s4Dat[p]  <= '0;
            rdyQ[p]   <= 1'b0;  datQ[p]   <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            // A request with both strobes high is a write.
            s1Vld[p]  <= rdIn[p] | wrIn[p];
            s1Wr[p]   <= wrIn[p];
            s1Addr[p] <= addrIn[p];
            s1Dat[p]  <= datIn[p];
            s2Vld[p]  <= s1Vld[p];
            s2Wr[p]   <= s1Wr[p];
            s2Addr[p] <= s1Addr[p];
            s2Dat[p]  <= s1Dat[p];
            s3Vld[p]  <= s2Vld[p] & ~s2Wr[p];
            s3Node[p] <= s2Addr[p][AW-1 -: NAW];
            s4Vld[p]  <= s3Vld[p];
            s4Dat[p]  <= bankRdDat[s3Node[p]][p];
            rdyQ[p]   <= s4Vld[p];
            if (s4Vld[p]) datQ[p] <= s4Dat[p];
         end
      end
   end

   for (genvar n = 0; n < NODES; n++) begin : gBank
      logic bankWrEn [NUM_PORTS];

      always_comb begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            bankWrEn[p] = s2Vld[p] & s2Wr[p] & (s2Addr[p][AW-1 -: NAW] == NAW'(n));
         end
      end

      cache_bank #(
         .DATA_WIDTH        (DATA_WIDTH),
         .WORD_ADDRESS_WIDTH(WAW)
      ) uBank (
         .clk   (clk),
         .reset (reset),
         .wrEn  (bankWrEn),
         .wrAddr(s2Word),
         .wrDat (s2Dat),
         .rdAddr(s2Word),
         .rdDat (bankRdDat[n])
      );
   end

   assign readReady_port0 = rdyQ[0];
   assign readReady_port1 = rdyQ[1];
   assign readReady_port2 = rdyQ[2];
   assign readReady_port3 = rdyQ[3];
   assign dataOut_port0   = datQ[0];
   assign dataOut_port1   = datQ[1];
   assign dataOut_port2   = datQ[2];
   assign dataOut_port3   = datQ[3];
endmodule

// File: tb/tb_network.sv
// Directed scenarios followed by random traffic, every cycle checked against a delayed-operation memory model.
module tb_network;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] dAddr [4];
   logic       dRd   [4];
   logic       dWr   [4];
   logic [7:0] dDat  [4];
   logic       rdy   [4];
   logic [7:0] dout  [4];

   always #5 clk = ~clk;

   network dut (
      .clk(clk), .reset(rst),
      .destinationAddressIn_port0(dAddr[0]), .readIn_port0(dRd[0]), .writeIn_port0(dWr[0]),
      .dataIn_port0(dDat[0]), .readReady_port0(rdy[0]), .dataOut_port0(dout[0]),
      .destinationAddressIn_port1(dAddr[1]), .readIn_port1(dRd[1]), .writeIn_port1(dWr[1]),
      .dataIn_port1(dDat[1]), .readReady_port1(rdy[1]), .dataOut_port1(dout[1]),
      .destinationAddressIn_port2(dAddr[2]), .readIn_port2(dRd[2]), .writeIn_port2(dWr[2]),
      .dataIn_port2(dDat[2]), .readReady_port2(rdy[2]), .dataOut_port2(dout[2]),
      .destinationAddressIn_port3(dAddr[3]), .readIn_port3(dRd[3]), .writeIn_port3(dWr[3]),
      .dataIn_port3(dDat[3]), .readReady_port3(rdy[3]), .dataOut_port3(dout[3])
   );

   typedef struct {
      int         due;
      int         port;
      bit         wr;
      logic [5:0] addr;
      logic [7:0] dat;
   } pend_t;

   typedef struct {
      int         cyc;
      logic [7:0] dat;
   } rsp_t;

   int         nAssert = 0;
   int         nFail   = 0;
   int         cyc     = 0;
   logic [7:0] mem [64];
   logic [7:0] lastRead [4];
   pend_t      pendQ [$];
   rsp_t       expQ [4][$];
   logic [7:0] gotQ [4][$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chkGot(input string tag, input int p, input int idx, input logic [7:0] exp);
      logic [7:0] v;
      v = (gotQ[p].size() > idx) ? gotQ[p][idx] : 8'hxx;
      chk(tag, {24'd0, v}, {24'd0, exp});
   endtask

   // Memory model: every accepted request acts two edges later, reads before writes,
   // lower port wins on same-word writes; a read's data is expected two edges after it acts.
   task automatic modelEdge();
      pend_t pe;
      rsp_t  rs;
      cyc++;
      if (!rst) begin
         foreach (mem[i]) mem[i] = 8'h00;
         pendQ.delete();
         for (int p = 0; p < 4; p++) begin
            expQ[p].delete();
            lastRead[p] = 8'h00;
         end
         return;
      end
      foreach (pendQ[i]) begin
         if (pendQ[i].due == cyc && !pendQ[i].wr) begin
            rs.cyc = cyc + 2;
            rs.dat = mem[pendQ[i].addr];
            expQ[pendQ[i].port].push_back(rs);
         end
      end
      for (int p = 3; p >= 0; p--) begin
         foreach (pendQ[i]) begin
            if (pendQ[i].due == cyc && pendQ[i].wr && pendQ[i].port == p)
               mem[pendQ[i].addr] = pendQ[i].dat;
         end
      end
      while (pendQ.size() > 0 && pendQ[0].due == cyc) void'(pendQ.pop_front());
      for (int p = 0; p < 4; p++) begin
         if (dRd[p] || dWr[p]) begin
            pe.due  = cyc + 2;
            pe.port = p;
            pe.wr   = dWr[p];
            pe.addr = dAddr[p];
            pe.dat  = dDat[p];
            pendQ.push_back(pe);
         end
      end
   endtask

   task automatic checkOutputs();
      logic       expRdy;
      logic [7:0] expDat;
      for (int p = 0; p < 4; p++) begin
         expRdy = 1'b0;
         expDat = lastRead[p];
         if (expQ[p].size() > 0 && expQ[p][0].cyc == cyc) begin
            expRdy      = 1'b1;
            expDat      = expQ[p][0].dat;
            lastRead[p] = expDat;
            void'(expQ[p].pop_front());
         end
         chk($sformatf("readReady_port%0d@%0d", p, cyc), {31'd0, rdy[p]}, {31'd0, expRdy});
         chk($sformatf("dataOut_port%0d@%0d", p, cyc), {24'd0, dout[p]}, {24'd0, expDat});
         if (rdy[p] === 1'b1) gotQ[p].push_back(dout[p]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutputs();
   endtask

   task automatic idle();
      for (int p = 0; p < 4; p++) begin
         dRd[p] = 1'b0; dWr[p] = 1'b0; dAddr[p] = 6'h00; dDat[p] = 8'h00;
      end
   endtask

   task automatic req(input int p, input bit rd, input bit wr, input logic [5:0] a, input logic [7:0] d);
      dRd[p] = rd; dWr[p] = wr; dAddr[p] = a; dDat[p] = d;
   endtask

   task automatic clearGot();
      for (int p = 0; p < 4; p++) gotQ[p].delete();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      for (int p = 0; p < 4; p++) lastRead[p] = 8'h00;

      // Reset held two cycles, then a read of a cleared word.
      tick(); tick();
      for (int p = 0; p < 4; p++) chk($sformatf("reset_rdy%0d", p), {31'd0, rdy[p]}, 32'd0);
      rst = 1'b1;
      req(0, 1, 0, 6'h05, 8'h00); tick(); idle();
      repeat (6) tick();
      chk("reset_read_count", gotQ[0].size(), 1);
      chkGot("reset_read_data", 0, 0, 8'h00);
      clearGot();

      // Remote write, then read from another port two cycles later.
      req(0, 0, 1, 6'h33, 8'hA5); tick(); idle(); tick();
      req(3, 1, 0, 6'h33, 8'h00); tick(); idle();
      repeat (6) tick();
      chk("remote_count", gotQ[3].size(), 1);
      chkGot("remote_data", 3, 0, 8'hA5);
      clearGot();

      // Same-word write collision: lower port wins.
      req(1, 0, 1, 6'h10, 8'h11); req(2, 0, 1, 6'h10, 8'h22); tick(); idle(); tick();
      req(0, 1, 0, 6'h10, 8'h00); tick(); idle();
      repeat (6) tick();
      chkGot("collision_data", 0, 0, 8'h11);
      clearGot();

      // Same-edge read/write: read sees the old word, re-read sees the new one.
      req(0, 0, 1, 6'h21, 8'h7E); req(1, 1, 0, 6'h21, 8'h00); tick(); idle();
      req(1, 1, 0, 6'h21, 8'h00); tick(); idle();
      repeat (6) tick();
      chk("hazard_count", gotQ[1].size(), 2);
      chkGot("hazard_old", 1, 0, 8'h00);
      chkGot("hazard_new", 1, 1, 8'h7E);
      clearGot();

      // Four banks written at once, then four back-to-back reads from one port.
      req(0, 0, 1, 6'h00, 8'd1); req(1, 0, 1, 6'h10, 8'd2);
      req(2, 0, 1, 6'h20, 8'd3); req(3, 0, 1, 6'h30, 8'd4);
      tick(); idle(); tick();
      for (int i = 0; i < 4; i++) begin
         req(2, 1, 0, 6'(i * 16), 8'h00); tick();
      end
      idle();
      repeat (6) tick();
      chk("burst_count", gotQ[2].size(), 4);
      for (int i = 0; i < 4; i++) chkGot($sformatf("burst_data%0d", i), 2, i, 8'(i + 1));
      clearGot();

      // Write in flight when reset asserts is discarded.
      req(0, 0, 1, 6'h05, 8'h5A); tick(); idle();
      rst = 1'b0; tick(); rst = 1'b1;
      repeat (5) tick();
      for (int p = 0; p < 4; p++) chk($sformatf("midreset_noresp%0d", p), gotQ[p].size(), 0);
      req(0, 1, 0, 6'h05, 8'h00); tick(); idle();
      repeat (6) tick();
      chkGot("midreset_word", 0, 0, 8'h00);
      clearGot();

      // Random traffic on a small address set to force collisions and hazards.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         for (int p = 0; p < 4; p++) begin
            dRd[p]   = ($urandom_range(0, 1) == 0);
            dWr[p]   = ($urandom_range(0, 3) == 0);
            dAddr[p] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            dDat[p]  = 8'($urandom);
         end
         tick();
      end
      rst = 1'b1;
      idle();
      repeat (8) tick();
      for (int p = 0; p < 4; p++) chk($sformatf("drain_port%0d", p), expQ[p].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
